myproject_mul_arbiter: RTL and testbench

MYPROJECT_MUL_ARBITER -- requirements
Module: myproject_mul_arbiter

---
 rtl/myproject_mul_arb_pkg.sv | 34 +++
 rtl/myproject_rr_arbiter.sv | 33 +++
 rtl/myproject_mul_arbiter.sv | 123 ++++++++++++
 tb/tb_myproject_mul_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/myproject_mul_arb_pkg.sv
// Shared constants, the ID-width helper and the pipeline stage record
// for the shared signed multiplier with round-robin arbitration.
package myproject_mul_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DIN0_WIDTH = 32;
    localparam int DEF_DIN1_WIDTH = 14;
    localparam int DEF_DOUT_WIDTH = DEF_DIN0_WIDTH + DEF_DIN1_WIDTH;
    localparam int DEF_MUL_STAGES = 2;

    // Number of bits needed to index n items (n >= 2).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int DEF_ID_WIDTH = clog2(DEF_NUM_REQ);

    // One pipeline stage. The product is formed on entry to the first stage,
    // so later stages only carry valid/id/product. The record is sized by the
    // package defaults; width overrides on the top must be mirrored here.
    typedef struct packed {
        logic                             valid;
        logic [DEF_ID_WIDTH-1:0]          id;
        logic signed [DEF_DOUT_WIDTH-1:0] prod;
    } stage_t;

endpackage

// File: rtl/myproject_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr with wrap and
// grants the first requester whose req bit is high.
module myproject_rr_arbiter
    import myproject_mul_arb_pkg::*;
#(
    parameter int N   = DEF_NUM_REQ,
    parameter int IDW = clog2(DEF_NUM_REQ)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx,
    output logic           any
);

    // Rotating priority search starting at ptr; first hit wins.
    always_comb begin
        int j;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/myproject_mul_arbiter.sv
// Shared full-precision signed multiplier fed by NUM_REQ requesters through a
// round-robin arbiter, with a MUL_STAGES-deep stallable result pipeline.
//
// Handshakes: a request transfers on requester i when req_valid[i] and
// req_ready[i] are high at a rising edge; a response transfers when rsp_valid
// and rsp_ready are high. The whole pipeline moves only when advance =
// !rsp_valid || rsp_ready; req_ready is the arbiter grant gated by advance,
// so at most one requester is accepted per cycle and never while stalled.
module myproject_mul_arbiter
    import myproject_mul_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DIN0_WIDTH = DEF_DIN0_WIDTH,
    parameter int DIN1_WIDTH = DEF_DIN1_WIDTH,
    parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
    parameter int MUL_STAGES = DEF_MUL_STAGES
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0]   req_din0,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0]   req_din1,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [clog2(NUM_REQ)-1:0]       rsp_id,
    output logic [DOUT_WIDTH-1:0]           rsp_dout,
    output logic                            busy
);

    localparam int IDW  = clog2(NUM_REQ);
    localparam int LAST = MUL_STAGES - 1;

    logic [NUM_REQ-1:0]           grant;
    logic [IDW-1:0]               grant_idx;
    logic                         grant_any;
    logic [IDW-1:0]               ptr;
    logic                         advance;
    logic [DIN0_WIDTH-1:0]        a_sel;
    logic [DIN1_WIDTH-1:0]        b_sel;
    logic signed [DOUT_WIDTH-1:0] a_ext;
    logic signed [DOUT_WIDTH-1:0] b_ext;
    logic signed [DOUT_WIDTH-1:0] prod;
    stage_t                       stg [MUL_STAGES];

    myproject_rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // Pipeline moves when the output slot is empty or being consumed.
    always_comb begin
        advance   = !stg[LAST].valid || rsp_ready;
        req_ready = (advance && ap_rst_n) ? grant : '0;
    end

    // Select the granted requester's operands (grant is one-hot).
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel = req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
                b_sel = req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
            end
        end
    end

    // Sign-extend both operands to the product width; the low DOUT_WIDTH
    // bits of that product are the exact full-precision result.
    always_comb begin
        a_ext = {{(DOUT_WIDTH-DIN0_WIDTH){a_sel[DIN0_WIDTH-1]}}, a_sel};
        b_ext = {{(DOUT_WIDTH-DIN1_WIDTH){b_sel[DIN1_WIDTH-1]}}, b_sel};
        prod  = a_ext * b_ext;
    end

    // Multiply into stage 0, then plain shift registers for retiming.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                stg[i] <= '0;
            end
        end else if (advance) begin
            stg[0].valid <= grant_any;
            stg[0].id    <= grant_idx;
            stg[0].prod  <= prod;
            for (int i = 1; i < MUL_STAGES; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    // Round-robin pointer moves past the winner only on a completed transfer.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr <= '0;
        end else if (advance && grant_any) begin
            if (int'(grant_idx) == NUM_REQ - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

    // Outputs come straight from the last stage; busy covers every stage.
    always_comb begin
        rsp_valid = stg[LAST].valid;
        rsp_id    = stg[LAST].id;
        rsp_dout  = stg[LAST].prod;
        busy      = 1'b0;
        for (int i = 0; i < MUL_STAGES; i++) begin
            busy = busy | stg[i].valid;
        end
    end

endmodule

// File: tb/tb_myproject_mul_arbiter.sv
// Directed bench for myproject_mul_arbiter: reset, sparse requests, single op,
// operand extremes, fairness, backpressure and reset mid-flight.
module tb_myproject_mul_arbiter;

    localparam int NR = 4;
    localparam int W0 = 32;
    localparam int W1 = 14;
    localparam int WO = 46;

    logic              ap_clk;
    logic              ap_rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*W0-1:0]  req_din0;
    logic [NR*W1-1:0]  req_din1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [WO-1:0]     rsp_dout;
    logic              busy;

    int n_cmp;
    int n_fail;

    myproject_mul_arbiter dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_din0  (req_din0),
        .req_din1  (req_din1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_dout  (rsp_dout),
        .busy      (busy)
    );

    // Clock
    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_din0[i*W0 +: W0] = a[W0-1:0];
        req_din1[i*W1 +: W1] = b[W1-1:0];
    endtask

    function automatic logic [WO-1:0] s46(input int v);
        logic [WO-1:0] r;
        r = v;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] id, input logic [WO-1:0] dout);
        check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        check({tag, "_id"}, 64'(rsp_id), 64'(id));
        check({tag, "_dout"}, 64'(rsp_dout), 64'(dout));
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        ap_rst_n  = 1'b0;
        req_valid = '0;
        req_din0  = '0;
        req_din1  = '0;
        rsp_ready = 1'b1;

        // ---- reset state
        tick();
        tick();
        req_valid = 4'hF;
        settle();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dout", 64'(rsp_dout), 64'd0);
        check("rst_id", 64'(rsp_id), 64'd0);
        req_valid = '0;
        ap_rst_n  = 1'b1;

        // ---- sparse: only requester 3, then only requester 1
        set_op(3, 5, 7);
        req_valid = 4'b1000;
        settle();
        check("sparse3_ready", 64'(req_ready), 64'b1000);
        tick();
        req_valid = 4'hF;
        settle();
        check("sparse_ptr0_probe", 64'(req_ready), 64'b0001);
        set_op(1, -6, 9);
        req_valid = 4'b0010;
        settle();
        check("sparse1_ready", 64'(req_ready), 64'b0010);
        check("sparse_lat_valid", 64'(rsp_valid), 64'd0);
        tick();
        check_rsp("sparse3_rsp", 2'd3, s46(35));
        req_valid = 4'hF;
        settle();
        check("sparse_ptr2_probe", 64'(req_ready), 64'b0100);
        req_valid = '0;
        tick();
        check_rsp("sparse1_rsp", 2'd1, s46(-54));
        tick();
        check("sparse_idle_valid", 64'(rsp_valid), 64'd0);
        check("sparse_idle_busy", 64'(busy), 64'd0);

        // ---- single op from requester 2 (ptr = 2)
        set_op(2, 1000, -3);
        req_valid = 4'b0100;
        settle();
        check("single_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        check("single_t0_valid", 64'(rsp_valid), 64'd0);
        check("single_t0_busy", 64'(busy), 64'd1);
        tick();
        check_rsp("single_rsp", 2'd2, s46(-3000));
        tick();
        check("single_done_valid", 64'(rsp_valid), 64'd0);

        // ---- operand extremes from requester 3 (ptr = 3, then 0)
        set_op(3, 32'h8000_0000, 14'h2000);
        req_valid = 4'b1000;
        settle();
        check("ext_min_ready", 64'(req_ready), 64'b1000);
        tick();
        set_op(3, 32'h7FFF_FFFF, 14'h1FFF);
        settle();
        check("ext_max_ready", 64'(req_ready), 64'b1000);
        tick();
        req_valid = '0;
        check_rsp("ext_min_rsp", 2'd3, 46'h1000_0000_0000);
        tick();
        check_rsp("ext_max_rsp", 2'd3, 46'h0FFF_7FFF_E001);
        tick();
        check("ext_done_valid", 64'(rsp_valid), 64'd0);

        // ---- fairness: all four valid continuously, ptr = 0
        for (int i = 0; i < NR; i++) begin
            set_op(i, 10 * (i + 1), -(i + 1));
        end
        req_valid = 4'hF;
        settle();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("fair_grant%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
            tick();
            if (k > 0) begin
                int m;
                m = ((k - 1) % 4) + 1;
                check_rsp($sformatf("fair_rsp%0d", k - 1), 2'((k - 1) % 4), s46(-10 * m * m));
            end
        end
        req_valid = '0;
        tick();
        check_rsp("fair_rsp7", 2'd3, s46(-160));
        tick();
        check("fair_done_valid", 64'(rsp_valid), 64'd0);

        // ---- backpressure: consumer stalls with the pipeline full
        set_op(0, 3, 4);
        set_op(1, -5, 6);
        set_op(2, 7, -8);
        rsp_ready = 1'b0;
        req_valid = 4'b0111;
        settle();
        check("bp_grant0", 64'(req_ready), 64'b0001);
        tick();
        req_valid = 4'b0110;
        settle();
        check("bp_grant1", 64'(req_ready), 64'b0010);
        check("bp_t1_valid", 64'(rsp_valid), 64'd0);
        tick();
        req_valid = 4'b0100;
        settle();
        check_rsp("bp_head", 2'd0, s46(12));
        check("bp_stall_ready", 64'(req_ready), 64'd0);
        for (int s = 0; s < 5; s++) begin
            tick();
            check($sformatf("bp_stall%0d_ready", s), 64'(req_ready), 64'd0);
            check_rsp($sformatf("bp_stall%0d", s), 2'd0, s46(12));
            check($sformatf("bp_stall%0d_busy", s), 64'(busy), 64'd1);
        end
        rsp_ready = 1'b1;
        settle();
        check("bp_release_grant2", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        check_rsp("bp_rsp1", 2'd1, s46(-30));
        tick();
        check_rsp("bp_rsp2", 2'd2, s46(-56));
        tick();
        check("bp_done_valid", 64'(rsp_valid), 64'd0);
        check("bp_done_busy", 64'(busy), 64'd0);

        // ---- reset mid-flight with two ops in the pipeline (ptr = 3)
        set_op(0, 11, 2);
        set_op(1, 13, 2);
        req_valid = 4'b0011;
        settle();
        check("rmf_grant0", 64'(req_ready), 64'b0001);
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        check("rmf_inflight_busy", 64'(busy), 64'd1);
        check("rmf_inflight_valid", 64'(rsp_valid), 64'd1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("rmf_valid", 64'(rsp_valid), 64'd0);
        check("rmf_busy", 64'(busy), 64'd0);
        check("rmf_dout", 64'(rsp_dout), 64'd0);
        check("rmf_id", 64'(rsp_id), 64'd0);
        req_valid = 4'hF;
        settle();
        check("rmf_ready_in_reset", 64'(req_ready), 64'd0);
        tick();
        check("rmf_hold_valid", 64'(rsp_valid), 64'd0);
        req_valid = '0;
        ap_rst_n  = 1'b1;
        settle();
        req_valid = 4'hF;
        settle();
        check("rmf_ptr_reset_probe", 64'(req_ready), 64'b0001);
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("rmf_nostale%0d_valid", c), 64'(rsp_valid), 64'd0);
            check($sformatf("rmf_nostale%0d_busy", c), 64'(busy), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
